// File: rtl/insn_fetch.sv
// insn_fetch: instruction fetch stage for the ELVM CPU.
//
// Owns the program counter and drives the ROM address straight from it.
// The ROM word that comes back in the same cycle is registered together
// with its PC and offered downstream over a valid/ready handshake.
// Execute can redirect fetch with a jump, which flushes the registered
// word, or stop it with a sticky halt that only reset clears.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rom_addr        ROM address (equal to pc)
//   rom_data        ROM word for rom_addr, same cycle
//   out_valid/ready handshake to decode/execute
//   out_insn/out_pc registered instruction and the address it came from
//   out_imm_sel .. out_imm   field slices of out_insn
//   jmp_valid/jmp_target     redirect request
//   halt / halted            halt request and sticky status
//   fetch_count              accepted handshakes, wraps at 2^16
module insn_fetch #(
    parameter int AW = 8,
    parameter int DW = 42
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_insn,
    output logic [AW-1:0] out_pc,
    output logic          out_imm_sel,
    output logic [4:0]    out_opcode,
    output logic [7:0]    out_field_a,
    output logic [2:0]    out_field_b,
    output logic          out_flag,
    output logic [23:0]   out_imm,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_target,
    input  logic          halt,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    logic [AW-1:0] pc;
    logic          fire;
    logic          load;

    assign rom_addr = pc;

    assign fire = out_valid & out_ready;
    // The output slot can take a new word when it is empty or being drained.
    assign load = ~halted & (~out_valid | out_ready);

    assign out_imm_sel = out_insn[41];
    assign out_opcode  = out_insn[40:36];
    assign out_field_a = out_insn[35:28];
    assign out_field_b = out_insn[27:25];
    assign out_flag    = out_insn[24];
    assign out_imm     = out_insn[23:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            out_valid   <= 1'b0;
            out_insn    <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // A handshake completing this cycle counts even if the same
            // cycle also halts or redirects.
            if (fire)
                fetch_count <= fetch_count + 16'd1;

            if (halt) begin
                halted    <= 1'b1;
                out_valid <= 1'b0;
            end else if (halted) begin
                // Frozen until reset; jumps are ignored.
                out_valid <= 1'b0;
            end else if (jmp_valid) begin
                // rom_data for the old pc is stale; drop it and the held word.
                pc        <= jmp_target;
                out_valid <= 1'b0;
            end else if (load) begin
                out_insn  <= rom_data;
                out_pc    <= pc;
                out_valid <= 1'b1;
                pc        <= pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
module tb_insn_fetch;

    localparam int AW = 8;
    localparam int DW = 42;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] insn;
    } item_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_insn;
    logic [AW-1:0] out_pc;
    logic          out_imm_sel;
    logic [4:0]    out_opcode;
    logic [7:0]    out_field_a;
    logic [2:0]    out_field_b;
    logic          out_flag;
    logic [23:0]   out_imm;
    logic          jmp_valid;
    logic [AW-1:0] jmp_target;
    logic          halt;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [DW-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    insn_fetch #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc),
        .out_imm_sel(out_imm_sel), .out_opcode(out_opcode),
        .out_field_a(out_field_a), .out_field_b(out_field_b),
        .out_flag(out_flag), .out_imm(out_imm),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .halt(halt), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_fire = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fetch stream as a sequence of addresses. Each
    // accepted slot delivers the next address; a redirect restarts the
    // stream at the target and empties the pending delivery; halt freezes.
    logic [AW-1:0] m_pc;
    bit            m_valid;
    bit            m_halted;
    logic [15:0]   m_cnt;
    item_t         exp_q[$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pc = '0; m_valid = 0; m_halted = 0; m_cnt = '0;
                exp_q.delete();
            end else begin
                if (m_valid && out_ready) m_cnt = m_cnt + 16'd1;
                if (halt) begin
                    m_halted = 1; m_valid = 0; exp_q.delete();
                end else if (!m_halted && jmp_valid) begin
                    m_pc = jmp_target; m_valid = 0; exp_q.delete();
                end else if (!m_halted && (!m_valid || out_ready)) begin
                    exp_q.push_back('{pc: m_pc, insn: rom[m_pc]});
                    m_pc = m_pc + 8'd1;
                    m_valid = 1;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, compares against the model
    // and retires the expected item when the handshake completes.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("out_valid", 64'(out_valid), 64'(m_valid));
                chk("halted", 64'(halted), 64'(m_halted));
                chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
                chk("rom_addr", 64'(rom_addr), 64'(m_pc));
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 64'(1), 64'(0));
                    end else begin
                        e = exp_q[0];
                        chk("out_pc", 64'(out_pc), 64'(e.pc));
                        chk("out_insn", 64'(out_insn), 64'(e.insn));
                        chk("out_imm_sel", 64'(out_imm_sel), 64'(e.insn[41]));
                        chk("out_opcode", 64'(out_opcode), 64'(e.insn[40:36]));
                        chk("out_field_a", 64'(out_field_a), 64'(e.insn[35:28]));
                        chk("out_field_b", 64'(out_field_b), 64'(e.insn[27:25]));
                        chk("out_flag", 64'(out_flag), 64'(e.insn[24]));
                        chk("out_imm", 64'(out_imm), 64'(e.insn[23:0]));
                        if (out_ready === 1'b1) begin
                            void'(exp_q.pop_front());
                            n_fire++;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for a given address at the output.
    task automatic wait_pc(input logic [AW-1:0] pc, input string name);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (out_valid === 1'b1 && out_pc === pc) seen = 1;
            else step(1);
        end
        chk(name, 64'(seen), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 42'(i + 'h100);
        rst = 1; out_ready = 0; jmp_valid = 0; jmp_target = '0; halt = 0;
        step(2);
        check_en = 1;
        rst = 0;

        // streaming at full rate
        out_ready = 1;
        step(8);

        // backpressure from the first valid word
        rst = 1; step(1); rst = 0;
        out_ready = 0;
        step(4);
        chk("stall_pc_held", 64'(out_pc), 64'(0));
        out_ready = 1;
        step(3);

        // redirect to 0x40 while out_pc=5 is presented
        rst = 1; step(1); rst = 0;
        wait_pc(8'h05, "reach_pc5");
        jmp_valid = 1; jmp_target = 8'h40;
        step(1);
        jmp_valid = 0;
        chk("jmp_bubble", 64'(out_valid), 64'(0));
        step(1);
        chk("jmp_target_pc", 64'(out_pc), 64'(8'h40));
        step(2);

        // wrap from 0xFE through 0xFF to 0x00
        jmp_valid = 1; jmp_target = 8'hFE;
        step(1);
        jmp_valid = 0;
        step(3);
        chk("wrap_pc", 64'(out_pc), 64'(8'h00));
        step(2);

        // halt together with a jump, then further jump pulses
        halt = 1; jmp_valid = 1; jmp_target = 8'h80;
        step(1);
        halt = 0; jmp_valid = 0;
        chk("halted_set", 64'(halted), 64'(1));
        for (int i = 0; i < 3; i++) begin
            jmp_valid = 1; jmp_target = 8'(8'h10 * i); step(1);
            jmp_valid = 0; step(1);
        end
        rst = 1; step(1); rst = 0;
        chk("halt_cleared", 64'(halted), 64'(0));
        step(3);

        // reset mid-stream at out_pc=0x20
        wait_pc(8'h20, "reach_pc20");
        rst = 1; step(1); rst = 0;
        chk("rst_valid", 64'(out_valid), 64'(0));
        step(1);
        chk("rst_restart_pc", 64'(out_pc), 64'(0));
        step(2);

        // randomized phase with random ROM contents
        rst = 1;
        for (int i = 0; i < 256; i++) rom[i] = {10'($urandom), 32'($urandom)};
        step(1);
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            jmp_valid  = ($urandom_range(0, 19) == 0);
            jmp_target = 8'($urandom);
            halt       = ($urandom_range(0, 299) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 0; jmp_valid = 0; halt = 0;
        step(2);
        chk("fires_seen", 64'(n_fire > 500), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_fetch.md
# insn_fetch

Instruction fetch stage for the ELVM CPU, sitting directly upstream of the 42-bit instruction ROM (8-bit address, combinational read). It owns the program counter, drives the ROM address, registers the returned word with its PC, and hands it to decode/execute over a valid/ready handshake. It supports jump redirect with flush and a sticky halt from execute.

## Interface
- AW, 8: ROM address / PC width.
- DW, 42: instruction word width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  AW  ROM address; combinationally equal to pc.
- rom_data  in  DW  ROM word for rom_addr, valid in the same cycle.
- out_valid  out  1  out_insn/out_pc hold a fetched instruction.
- out_ready  in  1  consumer accepts this cycle.
- out_insn  out  DW  registered instruction word.
- out_pc  out  AW  address out_insn was fetched from.
- out_imm_sel  out  1  out_insn[41].
- out_opcode  out  5  out_insn[40:36].
- out_field_a  out  8  out_insn[35:28].
- out_field_b  out  3  out_insn[27:25].
- out_flag  out  1  out_insn[24].
- out_imm  out  24  out_insn[23:0].
- jmp_valid  in  1  redirect request from execute.
- jmp_target  in  AW  redirect address.
- halt  in  1  stop fetching until reset.
- halted  out  1  sticky halt status.
- fetch_count  out  16  number of accepted handshakes.

## Operation
- State: pc (AW), output register (out_valid, out_insn, out_pc), halted, fetch_count.
- Field outputs are pure slices of out_insn; no extra register.
- fire = out_valid & out_ready. load = ~halted & (~out_valid | out_ready).
- Priority per cycle, highest first:
  - rst: pc=0, out_valid=0, out_insn=0, out_pc=0, halted=0, fetch_count=0.
  - halt: halted<=1, out_valid<=0, pc unchanged; a simultaneous jmp_valid is ignored. A fire in this cycle still counts.
  - jmp_valid (not halted): pc<=jmp_target, out_valid<=0; the registered instruction is flushed, and rom_data this cycle is discarded. A fire in this cycle still counts.
  - load: out_insn<=rom_data, out_pc<=pc, out_valid<=1, pc<=pc+1 mod 2^AW (255 wraps to 0).
  - otherwise (stalled: out_valid & ~out_ready): everything holds.
- When halted, pc, out_insn and out_pc hold. out_valid stays 0, and jmp_valid has no effect until rst.
- fetch_count increments by 1 on each fire and wraps at 2^16.
- Once asserted, out_valid with stable out_insn/out_pc persists until fire, jmp_valid, halt or rst.

## Timing
- rom_addr follows pc combinationally; no ROM pipeline stage is assumed.
- Fetch latency is 1 cycle. In the first cycle with rst low, pc=0 is fetched, and out_valid=1 with out_pc=0 follows the next edge.
- Throughput is 1 instruction/cycle while out_ready is held high.
- Redirect penalty is 1 bubble: the jmp_valid edge gives out_valid=0, and the next edge gives out_insn=ROM[jmp_target].
- Backpressure costs no bubble: in the out_ready-rising cycle, fire and load occur together.
- rst asserted mid-stream clears everything at that edge, regardless of halt or jmp_valid.

## Test plan
- Reset then out_ready=1 with ROM[i]=i+0x100: out_pc 0,1,2,… on consecutive cycles; out_insn matches; fetch_count increments each cycle.
- Hold out_ready=0 for 3 cycles after the first valid: out_pc=0 and out_insn stay stable, pc stays at 1, and fetch_count does not change. Then raising out_ready gives out_pc=1 on the next cycle with no gap.
- jmp_valid with jmp_target=0x40 while out_pc=5 is valid: the next cycle has out_valid=0, the following has out_pc=0x40 with ROM[0x40], then 0x41.
- Run from jmp_target=0xFE: out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- halt together with jmp_valid: halted=1, out_valid=0, and pc unchanged. Later jmp_valid pulses produce no output. rst then restarts fetch at pc=0 with halted=0 and fetch_count=0.
- Assert rst for 1 cycle mid-stream at out_pc=0x20: the next cycle has out_valid=0, the following has out_pc=0.
